// File: rtl/enemy_rom_if.sv
// Requester-side bundle for the shared enemy/projectile sprite ROM.
// Packed per-requester fields; slice i belongs to requester i.
interface enemy_rom_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_is_proj;
   logic [3*NUM_REQ-1:0] req_type;
   logic [3*NUM_REQ-1:0] req_frame;
   logic [5*NUM_REQ-1:0] req_y;
   logic [5*NUM_REQ-1:0] req_x;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [5:0]           rsp_data;
   logic                 rsp_transparent;

   modport master (
      output req_valid, req_is_proj, req_type, req_frame, req_y, req_x,
      input  req_ready, rsp_valid, rsp_data, rsp_transparent
   );

   modport slave (
      input  req_valid, req_is_proj, req_type, req_frame, req_y, req_x,
      output req_ready, rsp_valid, rsp_data, rsp_transparent
   );
endinterface

// File: rtl/enemy_rom_arbiter.sv
// Round-robin arbiter sharing the single-port sprite ROM among pixel
// fetchers; returns each pixel one-hot tagged after the ROM latency.
module enemy_rom_arbiter #(
   parameter int         NUM_REQ     = 4,
   parameter int         ROM_LATENCY = 1,
   parameter logic [15:0] PROJ_BASE  = 16'd49152,
   parameter logic [5:0] TRANS_COLOR = 6'h33
) (
   input  logic        clk,
   input  logic        reset,
   enemy_rom_if.slave  bus,
   output logic [15:0] rom_addr,
   input  logic [5:0]  rom_data
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [2:0] typ [NUM_REQ];
   logic [2:0] frm [NUM_REQ];
   logic [4:0] ys  [NUM_REQ];
   logic [4:0] xs  [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         typ[i] = bus.req_type[3*i +: 3];
         frm[i] = bus.req_frame[3*i +: 3];
         ys[i]  = bus.req_y[5*i +: 5];
         xs[i]  = bus.req_x[5*i +: 5];
      end
   end

   logic [PW-1:0]      rr_ptr;
   logic [PW-1:0]      gidx;
   logic               any;
   logic [NUM_REQ-1:0] grant;
   logic [PW:0]        sum;

   // Scan upward from rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      grant = '0;
      gidx  = '0;
      any   = 1'b0;
      sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NUM_REQ))
            sum = sum - (PW+1)'(NUM_REQ);
         if (!any && !reset && bus.req_valid[sum[PW-1:0]]) begin
            any  = 1'b1;
            gidx = sum[PW-1:0];
         end
      end
      if (any)
         grant[gidx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= '0;
      else if (any)
         rr_ptr <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
   end

   logic [15:0] enemy_addr;
   logic [15:0] proj_addr;
   logic [15:0] next_addr;
   logic [15:0] addr_q;
   logic        invalid;

   always_comb begin
      enemy_addr = {typ[gidx], frm[gidx], ys[gidx], xs[gidx]};
      proj_addr  = PROJ_BASE + {8'h00, ys[gidx][3:0], xs[gidx][3:0]};
      next_addr  = bus.req_is_proj[gidx] ? proj_addr : enemy_addr;
      invalid    = !bus.req_is_proj[gidx] && typ[gidx][2] && typ[gidx][1];
   end

   // Address holds its last issued value while idle
   always_ff @(posedge clk) begin
      if (reset)
         addr_q <= '0;
      else if (any)
         addr_q <= next_addr;
   end

   assign rom_addr = reset ? 16'h0000 : (any ? next_addr : addr_q);
   assign bus.req_ready = grant;

   logic [NUM_REQ-1:0] tag_oh  [ROM_LATENCY];
   logic               tag_inv [ROM_LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < ROM_LATENCY; s++) begin
            tag_oh[s]  <= '0;
            tag_inv[s] <= 1'b0;
         end
      end else begin
         tag_oh[0]  <= grant;
         tag_inv[0] <= any && invalid;
         for (int s = 1; s < ROM_LATENCY; s++) begin
            tag_oh[s]  <= tag_oh[s-1];
            tag_inv[s] <= tag_inv[s-1];
         end
      end
   end

   // Responses are squashed in a reset cycle so in-flight fetches vanish
   logic live;

   assign live = (|tag_oh[ROM_LATENCY-1]) && !reset;

   assign bus.rsp_valid = live ? tag_oh[ROM_LATENCY-1] : '0;
   assign bus.rsp_data  = live ? rom_data : 6'h00;
   assign bus.rsp_transparent =
      live && (tag_inv[ROM_LATENCY-1] || rom_data == TRANS_COLOR);

   a_grant_onehot : assert property (
      @(posedge clk) $onehot0(bus.req_ready));
   a_no_grant_in_reset : assert property (
      @(posedge clk) reset |-> bus.req_ready == '0);
   a_rsp_onehot : assert property (
      @(posedge clk) $onehot0(bus.rsp_valid));
endmodule

// File: tb/tb_enemy_rom_arbiter.sv
// Self-checking bench: directed vector table, fairness sequence, and
// randomized traffic against a queue-based reference model.
module tb_enemy_rom_arbiter;
   localparam int N   = 4;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rom_addr;
   logic [5:0]  rom_data;

   enemy_rom_if #(.NUM_REQ(N)) bus ();

   enemy_rom_arbiter #(
      .NUM_REQ(N),
      .ROM_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int          due;
      int          idx;
      logic [15:0] addr;
      bit          inv;
   } pend_t;

   pend_t       pend[$];
   int          ptr = 0;
   logic [15:0] last_addr = 16'h0000;

   logic [2:0]   ft [N];
   logic [2:0]   ff [N];
   logic [4:0]   fy [N];
   logic [4:0]   fx [N];
   logic [N-1:0] vmask;
   logic [N-1:0] pmask;

   function automatic logic [5:0] rom_fn(input logic [15:0] a);
      if (a == 16'hC0FF)
         return 6'h33;
      return a[5:0] ^ a[11:6] ^ {2'b00, a[15:12]} ^ 6'h15;
   endfunction

   function automatic logic [15:0] addr_of(input int i);
      int v;
      if (pmask[i])
         v = 49152 + int'(fy[i][3:0]) * 16 + int'(fx[i][3:0]);
      else
         v = int'(ft[i]) * 8192 + int'(ff[i]) * 1024
           + int'(fy[i]) * 32 + int'(fx[i]);
      return 16'(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic step(output logic [N-1:0] rdy, output logic [15:0] addr);
      int           g;
      logic [N-1:0] eg;
      logic [15:0]  ea;
      logic [5:0]   d;
      bit           hv;
      pend_t        p;
      bus.req_valid   = vmask;
      bus.req_is_proj = pmask;
      for (int i = 0; i < N; i++) begin
         bus.req_type[3*i +: 3]  = ft[i];
         bus.req_frame[3*i +: 3] = ff[i];
         bus.req_y[5*i +: 5]     = fy[i];
         bus.req_x[5*i +: 5]     = fx[i];
      end
      #2;
      g = -1;
      if (!reset)
         for (int k = 0; k < N; k++)
            if (g < 0 && vmask[(ptr + k) % N])
               g = (ptr + k) % N;
      eg = (g >= 0) ? N'(1) << g : '0;
      ea = reset ? 16'h0000 : ((g >= 0) ? addr_of(g) : last_addr);
      hv = !reset && pend.size() > 0 && pend[0].due == cyc;
      chk("req_ready", 32'(bus.req_ready), 32'(eg));
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      if (hv) begin
         p = pend[0];
         d = rom_fn(p.addr);
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(N'(1) << p.idx));
         chk("rsp_data", 32'(bus.rsp_data), 32'(d));
         chk("rsp_transp", 32'(bus.rsp_transparent),
             32'(p.inv || d == 6'h33));
      end else begin
         chk("rsp_valid", 32'(bus.rsp_valid), 32'h0);
         chk("rsp_data", 32'(bus.rsp_data), 32'h0);
         chk("rsp_transp", 32'(bus.rsp_transparent), 32'h0);
      end
      rdy  = bus.req_ready;
      addr = rom_addr;
      @(posedge clk);
      rom_data = rom_fn(addr);
      if (reset) begin
         pend.delete();
         ptr = 0;
         last_addr = 16'h0000;
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc)
            void'(pend.pop_front());
         if (g >= 0) begin
            p.due  = cyc + LAT;
            p.idx  = g;
            p.addr = ea;
            p.inv  = !pmask[g] && ft[g] >= 3'd6;
            pend.push_back(p);
            ptr = (g + 1) % N;
            last_addr = ea;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst;
      logic [3:0]  v;
      logic [3:0]  p;
      logic [2:0]  t;
      logic [2:0]  f;
      logic [4:0]  y;
      logic [4:0]  x;
      logic [3:0]  rdy;
      logic [15:0] addr;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [N-1:0] r;
      logic [15:0]  a;
      int           cnt [N];
      tbl.push_back('{1, 4'b0000, 4'b0000, 3'd0, 3'd0, 5'd0,  5'd0,  4'b0000, 16'h0000});
      tbl.push_back('{0, 4'b0001, 4'b0000, 3'd2, 3'd5, 5'd3,  5'd7,  4'b0001, 16'h5467});
      tbl.push_back('{0, 4'b0000, 4'b0000, 3'd2, 3'd5, 5'd3,  5'd7,  4'b0000, 16'h5467});
      tbl.push_back('{0, 4'b0010, 4'b1111, 3'd0, 3'd0, 5'd15, 5'd15, 4'b0010, 16'hC0FF});
      tbl.push_back('{0, 4'b0000, 4'b1111, 3'd0, 3'd0, 5'd15, 5'd15, 4'b0000, 16'hC0FF});
      tbl.push_back('{0, 4'b0001, 4'b0000, 3'd7, 3'd0, 5'd0,  5'd0,  4'b0001, 16'hE000});
      tbl.push_back('{0, 4'b0000, 4'b0000, 3'd7, 3'd0, 5'd0,  5'd0,  4'b0000, 16'hE000});
      tbl.push_back('{1, 4'b0000, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0000, 16'h0000});
      tbl.push_back('{0, 4'b0100, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0100, 16'h2421});
      tbl.push_back('{0, 4'b0101, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0001, 16'h2421});
      tbl.push_back('{0, 4'b0100, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0100, 16'h2421});
      tbl.push_back('{1, 4'b0000, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0000, 16'h0000});
      for (int k = 0; k < 8; k++)
         tbl.push_back('{0, 4'b1111, 4'b0000, 3'd1, 3'd1, 5'd1, 5'd1,
                         4'(1 << (k % 4)), 16'h2421});
      tbl.push_back('{0, 4'b0010, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0010, 16'h2421});
      tbl.push_back('{1, 4'b1111, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0000, 16'h0000});
      tbl.push_back('{0, 4'b0110, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0010, 16'h2421});
      tbl.push_back('{0, 4'b0000, 4'b0000, 3'd1, 3'd1, 5'd1,  5'd1,  4'b0000, 16'h2421});

      reset    = 1'b1;
      rom_data = 6'h00;
      vmask    = '0;
      pmask    = '0;
      for (int i = 0; i < N; i++) begin
         ft[i] = '0; ff[i] = '0; fy[i] = '0; fx[i] = '0;
      end
      @(negedge clk);

      foreach (tbl[j]) begin
         reset = tbl[j].rst;
         vmask = tbl[j].v;
         pmask = tbl[j].p;
         for (int i = 0; i < N; i++) begin
            ft[i] = tbl[j].t; ff[i] = tbl[j].f;
            fy[i] = tbl[j].y; fx[i] = tbl[j].x;
         end
         step(r, a);
         chk("tbl_ready", 32'(r), 32'(tbl[j].rdy));
         chk("tbl_addr", 32'(a), 32'(tbl[j].addr));
      end

      // Fairness: all requesting for 3*N cycles grants each exactly 3 times
      for (int i = 0; i < N; i++)
         cnt[i] = 0;
      reset = 1'b0;
      vmask = '1;
      for (int k = 0; k < 3 * N; k++) begin
         step(r, a);
         for (int i = 0; i < N; i++)
            if (r[i])
               cnt[i]++;
      end
      for (int i = 0; i < N; i++)
         chk("fair_count", 32'(cnt[i]), 32'd3);

      for (int k = 0; k < 3000; k++) begin
         reset = ($urandom_range(59) == 0);
         vmask = N'($urandom);
         pmask = N'($urandom);
         for (int i = 0; i < N; i++) begin
            ft[i] = 3'($urandom);
            ff[i] = 3'($urandom);
            fy[i] = 5'($urandom);
            fx[i] = 5'($urandom);
         end
         step(r, a);
      end

      reset = 1'b0;
      vmask = '0;
      step(r, a);
      step(r, a);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
